// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM states, round constants, initial hash value,
// and the bitwise round functions used by the sequencer and message schedule.
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    localparam int unsigned SS0_ROT1 = 7;
    localparam int unsigned SS0_ROT2 = 18;
    localparam int unsigned SS0_SHR  = 3;
    localparam int unsigned SS1_ROT1 = 17;
    localparam int unsigned SS1_ROT2 = 19;
    localparam int unsigned SS1_SHR  = 10;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, SS0_ROT1) ^ rotr(x, SS0_ROT2) ^ (x >> SS0_SHR);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, SS1_ROT1) ^ rotr(x, SS1_ROT2) ^ (x >> SS1_SHR);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word sliding message-schedule window. Entry 0 always holds W_t; each
// load or expand step shifts the window down by one and appends at entry 15.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        load_shift,
    input  logic        expand_shift,
    input  logic [31:0] word_in,
    output logic [31:0] w_t
);

    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_next;

    // With win[j] = W_{t+j}, the new tail is W_{t+16}.
    assign w_next = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
    assign w_t    = win_q[0];

    always_comb begin
        win_d = win_q;
        if (load_shift || expand_shift) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = load_shift ? word_in : w_next;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

endmodule

// File: rtl/sha256_round_sequencer.sv
// One SHA-256 block compression: 16-word load, NUM_ROUNDS rounds at one per
// cycle, chaining-state update and a one-cycle done pulse.
module sha256_round_sequencer
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         init_sel,
    input  logic         word_valid,
    input  logic [31:0]  word_in,
    output logic         word_ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    localparam int RW = $clog2(NUM_ROUNDS);

    state_e          state_q, state_d;
    logic [3:0]      load_cnt_q, load_cnt_d;
    logic [RW-1:0]   round_q, round_d;
    logic [31:0]     wv_q [8];
    logic [31:0]     wv_d [8];
    logic [31:0]     h_q [8];
    logic [31:0]     h_d [8];
    logic [255:0]    digest_q, digest_d;

    logic            accept;
    logic [31:0]     w_t;
    logic [31:0]     t1;
    logic [31:0]     t2;

    assign word_ready = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign digest     = digest_q;
    assign accept     = word_valid & word_ready;

    sha256_msg_schedule u_sched (
        .clk          (clk),
        .load_shift   (accept),
        .expand_shift (state_q == S_ROUND),
        .word_in      (word_in),
        .w_t          (w_t)
    );

    // wv index 0..7 corresponds to working registers a..h.
    assign t1 = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[round_q] + w_t;
    assign t2 = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        round_d    = round_q;
        wv_d       = wv_q;
        h_d        = h_q;
        digest_d   = digest_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    load_cnt_d = '0;
                    for (int i = 0; i < 8; i++) begin
                        h_d[i] = init_sel ? IV[i] : digest_q[255 - 32*i -: 32];
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d = S_ROUND;
                        round_d = '0;
                        wv_d    = h_q;
                    end
                end
            end
            S_ROUND: begin
                wv_d[0] = t1 + t2;
                wv_d[1] = wv_q[0];
                wv_d[2] = wv_q[1];
                wv_d[3] = wv_q[2];
                wv_d[4] = wv_q[3] + t1;
                wv_d[5] = wv_q[4];
                wv_d[6] = wv_q[5];
                wv_d[7] = wv_q[6];
                if (round_q == RW'(NUM_ROUNDS - 1)) begin
                    state_d = S_FINAL;
                end else begin
                    round_d = round_q + RW'(1);
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i]                      = h_q[i] + wv_q[i];
                    digest_d[255 - 32*i -: 32]  = h_q[i] + wv_q[i];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            round_q    <= '0;
            wv_q       <= '{default: '0};
            h_q        <= '{default: '0};
            digest_q   <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            round_q    <= round_d;
            wv_q       <= wv_d;
            h_q        <= h_d;
            digest_q   <= digest_d;
        end
    end

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Directed bench for sha256_round_sequencer with a block-level SHA-256
// reference model and per-cycle output comparison.
module tb_sha256_round_sequencer;

    localparam int LAT_FINAL = 65;
    localparam int LAT_DONE  = 66;
    localparam logic [255:0] TIV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk;
    logic         rst;
    logic         start;
    logic         init_sel;
    logic         word_valid;
    logic [31:0]  word_in;
    logic         word_ready;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    // reference model state: 0 idle, 1 collecting words, 2 counting cycles after 16th word
    int           m_mode = 0;
    int           m_words = 0;
    int           m_cnt = 0;
    logic [511:0] m_blk;
    logic [255:0] m_h;
    logic [255:0] m_digest;

    sha256_round_sequencer #(.NUM_ROUNDS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_sel   (init_sel),
        .word_valid (word_valid),
        .word_in    (word_in),
        .word_ready (word_ready),
        .busy       (busy),
        .done       (done),
        .digest     (digest)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x} >> n;
        return xx[31:0];
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
            t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
            s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
            t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode   <= 0;
            m_words  <= 0;
            m_cnt    <= 0;
            m_digest <= '0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode  <= 1;
                    m_words <= 0;
                    m_h     <= init_sel ? TIV : m_digest;
                end
                1: if (word_valid) begin
                    m_blk[511 - 32*m_words -: 32] <= word_in;
                    m_words <= m_words + 1;
                    if (m_words == 15) begin
                        m_mode <= 2;
                        m_cnt  <= 1;
                    end
                end
                default: begin
                    if (m_cnt == LAT_FINAL) m_digest <= compress(m_h, m_blk);
                    if (m_cnt == LAT_DONE) m_mode <= 0;
                    else m_cnt <= m_cnt + 1;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 256'(busy), 256'(m_mode != 0));
            chk("word_ready", 256'(word_ready), 256'(m_mode == 1));
            chk("done", 256'(done), 256'(m_mode == 2 && m_cnt == LAT_DONE));
            chk("digest", digest, m_digest);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic do_start(input logic init);
        start = 1'b1;
        init_sel = init;
        @(posedge clk); #1;
        start = 1'b0;
        init_sel = 1'b0;
    endtask

    task automatic send_block(input logic [511:0] blk, input int maxgap, output int acc);
        int gap;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            word_valid = 1'b1;
            word_in = blk[511 - 32*i -: 32];
            acc = cyc;
            @(posedge clk); #1;
            word_valid = 1'b0;
            word_in = '0;
        end
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        bit found;
        found = 0;
        dcyc = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                dcyc = cyc;
            end
        end
        if (!found) begin
            errors++;
            $display("FAIL done_timeout cyc=%0d got=no_done exp=done_within_%0d", cyc, budget);
        end
    endtask

    task automatic run_block(input string name, input logic [511:0] blk, input logic init, input int maxgap,
                             input bit chk_dig, input logic [255:0] exp);
        int acc, dcyc;
        do_start(init);
        send_block(blk, maxgap, acc);
        wait_done(200, dcyc);
        chk({name, "_latency"}, 256'(dcyc - acc), 256'(66));
        if (chk_dig) begin
            chk({name, "_digest"}, digest, exp);
            chk({name, "_model"}, m_digest, exp);
        end
        @(posedge clk); #1;
    endtask

    logic [511:0] blk_abc, blk_empty, blk_2a, blk_2b;
    logic [255:0] d_abc, d_empty, d_two;

    initial begin
        int acc, d0;
        blk_abc   = {32'h61626380, 448'd0, 32'h00000018};
        blk_empty = {32'h80000000, 480'd0};
        blk_2a    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_2b    = {480'd0, 32'h000001c0};
        d_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        d_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
        d_two   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

        rst = 1'b1; start = 1'b0; init_sel = 1'b0; word_valid = 1'b0; word_in = '0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_ready", 256'(word_ready), 256'(0));
        chk("reset_done", 256'(done), 256'(0));
        chk("reset_digest", digest, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_block("abc", blk_abc, 1'b1, 0, 1, d_abc);
        run_block("empty", blk_empty, 1'b1, 0, 1, d_empty);

        d0 = done_cnt;
        run_block("two_a", blk_2a, 1'b1, 0, 0, '0);
        run_block("two_b", blk_2b, 1'b0, 0, 1, d_two);
        chk("two_done_pulses", 256'(done_cnt - d0), 256'(2));

        run_block("stall", blk_abc, 1'b1, 5, 1, d_abc);

        // spurious start/word_valid during ROUND, then start during DONE
        do_start(1'b1);
        send_block(blk_abc, 0, acc);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            word_valid = 1'b1;
            word_in = $urandom();
            @(posedge clk); #1;
        end
        start = 1'b0; word_valid = 1'b0; word_in = '0;
        @(negedge clk);
        chk("spur_busy_round", 256'(busy), 256'(1));
        while (cyc < acc + 66) begin @(posedge clk); #1; end
        start = 1'b1;
        @(negedge clk);
        chk("spur_done", 256'(done), 256'(1));
        chk("spur_digest", digest, d_abc);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("spur_idle_busy", 256'(busy), 256'(0));
        @(posedge clk); #1;

        // reset while round t=30 is executing
        do_start(1'b1);
        send_block(blk_abc, 0, acc);
        while (cyc < acc + 31) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_digest", digest, 256'd0);
        @(posedge clk); #1;
        run_block("post_rst", blk_abc, 1'b1, 0, 1, d_abc);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
